// File: rtl/ampel_pkg.sv
// Shared state encoding and default durations for the multi-phase traffic light.
package ampel_pkg;

   localparam logic [2:0] ST_ALLROT = 3'd0;
   localparam logic [2:0] ST_RGELB  = 3'd1;
   localparam logic [2:0] ST_GRUEN  = 3'd2;
   localparam logic [2:0] ST_GELB   = 3'd3;
   localparam logic [2:0] ST_NACHT  = 3'd4;

   localparam int DEF_N_PH    = 3;
   localparam int DEF_TW      = 5;
   localparam int DEF_T_ROT   = 1;
   localparam int DEF_T_RGELB = 1;
   localparam int DEF_T_GRUEN = 15;
   localparam int DEF_T_GELB  = 1;
   localparam int DEF_T_FG    = 5;

endpackage

// File: rtl/ampel_timer.sv
// Loadable down-counter that times each light state; ready flags the last cycle.
module ampel_timer #(
   parameter int              TW      = 5,
   parameter logic [TW-1:0]   RST_VAL = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [TW-1:0] init,
   output logic [TW-1:0] count,
   output logic          ready
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= init;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign ready = (count == '0);

endmodule

// File: rtl/ampel_np.sv
// N-phase traffic light with pedestrian requests that shorten the running green.
// Optional night blink mode is built in when AMPEL_NACHT_EN is defined.
module ampel_np
   import ampel_pkg::*;
#(
   parameter int N_PH    = DEF_N_PH,
   parameter int TW      = DEF_TW,
   parameter int T_ROT   = DEF_T_ROT,
   parameter int T_RGELB = DEF_T_RGELB,
   parameter int T_GRUEN = DEF_T_GRUEN,
   parameter int T_GELB  = DEF_T_GELB,
   parameter int T_FG    = DEF_T_FG,
   localparam int PW     = $clog2(N_PH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_PH-1:0] f_an,
`ifdef AMPEL_NACHT_EN
   input  logic            night,
`endif
   output logic [N_PH-1:0] rt,
   output logic [N_PH-1:0] ge,
   output logic [N_PH-1:0] gr,
   output logic [N_PH-1:0] f_rt,
   output logic [N_PH-1:0] f_gr,
   output logic [N_PH-1:0] f_sg,
   output logic [PW-1:0]   phase,
   output logic [TW-1:0]   count,
   output logic [2:0]      state
);

   localparam logic [TW-1:0] I_ROT   = TW'(T_ROT - 1);
   localparam logic [TW-1:0] I_RGELB = TW'(T_RGELB - 1);
   localparam logic [TW-1:0] I_GRUEN = TW'(T_GRUEN - 1);
   localparam logic [TW-1:0] I_GELB  = TW'(T_GELB - 1);
   localparam logic [TW-1:0] I_FG    = TW'(T_FG - 1);
   localparam logic [PW-1:0] LAST_PH = PW'(N_PH - 1);

   logic [2:0]      state_n;
   logic [PW-1:0]   phase_n;
   logic            load;
   logic [TW-1:0]   init;
   logic            ready;
   logic [N_PH-1:0] sg_clr;
   logic [N_PH-1:0] sel;
   logic            req;

`ifdef AMPEL_NACHT_EN
   logic blink;
   logic blink_n;
`endif

   ampel_timer #(
      .TW      (TW),
      .RST_VAL (I_ROT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .init  (init),
      .count (count),
      .ready (ready)
   );

   assign sel = {{(N_PH-1){1'b0}}, 1'b1} << phase;
   assign req = f_sg[phase] | f_an[phase];

   always_comb begin
      state_n = state;
      phase_n = phase;
      load    = 1'b0;
      init    = '0;
      sg_clr  = '0;
`ifdef AMPEL_NACHT_EN
      blink_n = blink;
`endif
      case (state)
         ST_ALLROT: begin
            if (ready) begin
               state_n = ST_RGELB;
               phase_n = (phase == LAST_PH) ? '0 : phase + 1'b1;
               load    = 1'b1;
               init    = I_RGELB;
`ifdef AMPEL_NACHT_EN
               if (night) begin
                  state_n = ST_NACHT;
                  phase_n = phase;
                  init    = I_GELB;
                  blink_n = 1'b1;
               end
`endif
            end
         end
         ST_RGELB: begin
            // A request already pending when green starts gets the short green outright.
            if (ready) begin
               state_n = ST_GRUEN;
               load    = 1'b1;
               init    = req ? I_FG : I_GRUEN;
            end
         end
         ST_GRUEN: begin
            if (ready) begin
               state_n        = ST_GELB;
               load           = 1'b1;
               init           = I_GELB;
               sg_clr[phase]  = 1'b1;
            end else if (req && (count > I_FG)) begin
               load = 1'b1;
               init = I_FG;
            end
         end
         ST_GELB: begin
            if (ready) begin
               state_n = ST_ALLROT;
               load    = 1'b1;
               init    = I_ROT;
            end
         end
`ifdef AMPEL_NACHT_EN
         ST_NACHT: begin
            if (!night) begin
               state_n = ST_ALLROT;
               load    = 1'b1;
               init    = I_ROT;
            end else if (ready) begin
               blink_n = ~blink;
               load    = 1'b1;
               init    = I_GELB;
            end
         end
`endif
         default: begin
            state_n = ST_ALLROT;
            load    = 1'b1;
            init    = I_ROT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_ALLROT;
         phase <= LAST_PH;
         f_sg  <= '0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         // Clearing on GELB entry dominates a press in the same cycle.
         f_sg  <= (f_sg | f_an) & ~sg_clr;
      end
   end

`ifdef AMPEL_NACHT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink <= 1'b0;
      end else begin
         blink <= blink_n;
      end
   end
`endif

   always_comb begin
      rt   = '1;
      ge   = '0;
      gr   = '0;
      f_gr = '0;
      f_rt = '1;
      case (state)
         ST_RGELB: ge = sel;
         ST_GRUEN: begin
            rt   = ~sel;
            gr   = sel;
            f_gr = ~sel;
            f_rt = sel;
         end
         ST_GELB: begin
            rt = ~sel;
            ge = sel;
         end
`ifdef AMPEL_NACHT_EN
         ST_NACHT: begin
            rt   = '0;
            ge   = {N_PH{blink}};
            f_rt = '0;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ampel_np.sv
// Directed bench for ampel_np with default parameters (night mode not built).
module tb_ampel_np;
   import ampel_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] f_an = '0;
   logic [2:0] rt, ge, gr, f_rt, f_gr, f_sg;
   logic [1:0] phase;
   logic [4:0] count;
   logic [2:0] state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int viol    = 0;

   always #5 clk = ~clk;

   ampel_np dut (
      .clk   (clk),
      .reset (reset),
      .f_an  (f_an),
      .rt    (rt),
      .ge    (ge),
      .gr    (gr),
      .f_rt  (f_rt),
      .f_gr  (f_gr),
      .f_sg  (f_sg),
      .phase (phase),
      .count (count),
      .state (state)
   );

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic [1:0] ph;
      logic [4:0] cnt;
      logic [2:0] rt;
      logic [2:0] ge;
      logic [2:0] gr;
      logic [2:0] fgr;
   } vec_t;

   vec_t tbl[14];

   always @(negedge clk) begin
      if (!reset) begin
         if ($countones(gr) > 1) viol++;
         if ((gr & f_gr) != 3'b000) viol++;
      end
   end

   function automatic logic [27:0] snap();
      return {state, phase, count, rt, ge, gr, f_gr, f_rt};
   endfunction

   function automatic logic [27:0] expv(input logic [2:0] st, input logic [1:0] ph,
                                        input logic [4:0] cnt, input logic [2:0] r,
                                        input logic [2:0] g, input logic [2:0] n,
                                        input logic [2:0] fg);
      return {st, ph, cnt, r, g, n, fg, ~fg};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Called at posedge+1; asserts reset mid-cycle, checks, releases on the negedge.
   task automatic do_reset();
      f_an = '0;
      #1 reset = 1'b1;
      #2;
      chk("reset_vals", 64'(snap()), 64'(expv(ST_ALLROT, 2'd2, 5'd0, 3'b111, 3'b000, 3'b000, 3'b000)));
      chk("reset_fsg", 64'(f_sg), 64'(3'b000));
      #1 reset = 1'b0;
      cyc = 0;
   endtask

   initial begin
      tbl[0]  = '{0,  ST_ALLROT, 2'd2, 5'd0,  3'b111, 3'b000, 3'b000, 3'b000};
      tbl[1]  = '{1,  ST_RGELB,  2'd0, 5'd0,  3'b111, 3'b001, 3'b000, 3'b000};
      tbl[2]  = '{2,  ST_GRUEN,  2'd0, 5'd14, 3'b110, 3'b000, 3'b001, 3'b110};
      tbl[3]  = '{9,  ST_GRUEN,  2'd0, 5'd7,  3'b110, 3'b000, 3'b001, 3'b110};
      tbl[4]  = '{16, ST_GRUEN,  2'd0, 5'd0,  3'b110, 3'b000, 3'b001, 3'b110};
      tbl[5]  = '{17, ST_GELB,   2'd0, 5'd0,  3'b110, 3'b001, 3'b000, 3'b000};
      tbl[6]  = '{18, ST_ALLROT, 2'd0, 5'd0,  3'b111, 3'b000, 3'b000, 3'b000};
      tbl[7]  = '{19, ST_RGELB,  2'd1, 5'd0,  3'b111, 3'b010, 3'b000, 3'b000};
      tbl[8]  = '{20, ST_GRUEN,  2'd1, 5'd14, 3'b101, 3'b000, 3'b010, 3'b101};
      tbl[9]  = '{35, ST_GELB,   2'd1, 5'd0,  3'b101, 3'b010, 3'b000, 3'b000};
      tbl[10] = '{37, ST_RGELB,  2'd2, 5'd0,  3'b111, 3'b100, 3'b000, 3'b000};
      tbl[11] = '{38, ST_GRUEN,  2'd2, 5'd14, 3'b011, 3'b000, 3'b100, 3'b011};
      tbl[12] = '{54, ST_ALLROT, 2'd2, 5'd0,  3'b111, 3'b000, 3'b000, 3'b000};
      tbl[13] = '{55, ST_RGELB,  2'd0, 5'd0,  3'b111, 3'b001, 3'b000, 3'b000};

      repeat (3) @(posedge clk);
      #1;

      // Full rotation with no requests
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].cyc - cyc);
         chk($sformatf("rotation_c%0d", tbl[i].cyc), 64'(snap()),
             64'(expv(tbl[i].st, tbl[i].ph, tbl[i].cnt, tbl[i].rt, tbl[i].ge, tbl[i].gr, tbl[i].fgr)));
      end

      // Own-phase request at count 12 shortens green to 5 more cycles
      step(1);
      do_reset();
      step(4);
      chk("short_pre_count", 64'(count), 64'(5'd12));
      f_an = 3'b001;
      step(1);
      f_an = 3'b000;
      chk("short_count", 64'(count), 64'(5'd4));
      chk("short_fsg_set", 64'(f_sg), 64'(3'b001));
      step(4);
      chk("short_last_green", 64'({state, count}), 64'({ST_GRUEN, 5'd0}));
      step(1);
      chk("short_gelb", 64'({state, f_sg}), 64'({ST_GELB, 3'b000}));

      // Late request: no extension, flag set then cleared
      do_reset();
      step(14);
      f_an = 3'b001;
      step(1);
      f_an = 3'b000;
      chk("late_count", 64'({state, count, f_sg}), 64'({ST_GRUEN, 5'd1, 3'b001}));
      step(2);
      chk("late_gelb", 64'({state, f_sg}), 64'({ST_GELB, 3'b000}));

      // Request coinciding with count==0: GELB wins and clears
      do_reset();
      step(16);
      f_an = 3'b001;
      step(1);
      f_an = 3'b000;
      chk("tie_gelb", 64'({state, f_sg}), 64'({ST_GELB, 3'b000}));

      // Request for phase 2 during phase 0 green is held, then shortens phase 2
      do_reset();
      step(5);
      f_an = 3'b100;
      step(1);
      f_an = 3'b000;
      chk("p2_fsg_set", 64'(f_sg), 64'(3'b100));
      step(36 - cyc);
      chk("p2_fsg_held", 64'({state, phase, f_sg}), 64'({ST_ALLROT, 2'd1, 3'b100}));
      step(2);
      chk("p2_green_short", 64'({state, phase, count}), 64'({ST_GRUEN, 2'd2, 5'd4}));
      step(4);
      chk("p2_green_last", 64'({state, count}), 64'({ST_GRUEN, 5'd0}));
      step(1);
      chk("p2_gelb", 64'({state, phase, f_sg}), 64'({ST_GELB, 2'd2, 3'b000}));

      // Mid-cycle reset during green aborts without GELB
      do_reset();
      step(3);
      f_an = 3'b010;
      step(1);
      f_an = 3'b000;
      step(9 - cyc);
      chk("abort_pre", 64'({state, count, f_sg}), 64'({ST_GRUEN, 5'd7, 3'b010}));
      #2 reset = 1'b1;
      #1;
      chk("abort_vals", 64'(snap()), 64'(expv(ST_ALLROT, 2'd2, 5'd0, 3'b111, 3'b000, 3'b000, 3'b000)));
      chk("abort_fsg", 64'(f_sg), 64'(3'b000));
      #2 reset = 1'b0;
      cyc = 0;
      step(1);
      chk("abort_rgelb", 64'({state, phase}), 64'({ST_RGELB, 2'd0}));
      step(1);
      chk("abort_green", 64'({state, phase, gr}), 64'({ST_GRUEN, 2'd0, 3'b001}));

      chk("invariants", 64'(viol), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ampel_np.md
AMPEL_NP -- requirements
Module: ampel_np

Interface
REQ-001 SHALL have parameter N_PH, default 3, number of signal phases (roads served in rotation), range 2..8.
REQ-002 SHALL have parameter TW, default 5, timer width in bits.
REQ-003 SHALL have parameters T_ROT=1, T_RGELB=1, T_GRUEN=15, T_GELB=1, giving the cycle duration of each state; each is 1..2^TW.
REQ-004 SHALL have parameter T_FG, default 5, the shortened remaining green after a pedestrian request; 1 <= T_FG <= T_GRUEN.
REQ-005 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port f_an, input, N_PH bits, pedestrian request button per phase, level sampled each cycle.
REQ-008 SHALL have port night, input, 1 bit, night-mode request; present only with AMPEL_NACHT_EN.
REQ-009 SHALL have ports rt, ge, gr, outputs, N_PH bits each: red, yellow and green vehicle lamps per phase.
REQ-010 SHALL have ports f_rt, f_gr, f_sg, outputs, N_PH bits each: pedestrian red, pedestrian green, and request-acknowledged lamp.
REQ-011 SHALL have port phase, output, $clog2(N_PH) bits, active phase index.
REQ-012 SHALL have port count, output, TW bits, remaining cycles in the current state minus one.

Function
REQ-013 SHALL implement states ALLROT, RGELB, GRUEN and GELB (plus NACHT with the macro), with transitions ALLROT->RGELB->GRUEN->GELB->ALLROT.
REQ-014 SHALL load count with T_x-1 on entry to state x and decrement it each cycle; the state SHALL be left in the cycle count==0, so state x lasts exactly T_x cycles.
REQ-015 SHALL advance phase to (phase+1) mod N_PH on the ALLROT->RGELB transition, wrapping N_PH-1 to 0.
REQ-016 SHALL drive lamps for active phase p: ALLROT rt; RGELB rt+ge; GRUEN gr; GELB ge. All non-active phases SHALL show rt only.
REQ-017 SHALL set f_gr[i]=1 exactly when state==GRUEN and i!=p; f_rt SHALL equal ~f_gr.
REQ-018 SHALL set f_sg[i] on f_an[i]=1; f_sg[i] SHALL stay set until phase i enters GELB, and repeated presses while set SHALL have no effect.
REQ-019 In GRUEN with f_sg[p]=1 (or f_an[p]=1) and count > T_FG-1, SHALL load count with T_FG-1 next cycle; otherwise the green duration SHALL be unchanged.
REQ-020 When f_an[p] and count==0 occur together in GRUEN, the GELB transition SHALL win and f_sg[p] SHALL end cleared.
REQ-021 SHALL never assert gr of two phases at once, and SHALL never assert gr[p] and f_gr[p] together.

Reset
REQ-022 Reset SHALL force state=ALLROT, phase=N_PH-1, count=T_ROT-1, f_sg=0 and rt=all ones, ge=gr=f_gr=0, f_rt=all ones, immediately and independent of clk.
REQ-023 After reset deassertion, the first green SHALL be phase 0; reset asserted mid-cycle SHALL abort any state, including GRUEN, without an intervening GELB.

Configuration
REQ-024 With AMPEL_NACHT_EN defined: night=1 sampled at ALLROT exit SHALL enter NACHT; NACHT SHALL toggle all ge every T_GELB cycles (starting on) with rt, gr, f_rt, f_gr = 0; and night=0 SHALL return to ALLROT for a full T_ROT before resuming at phase+1.
REQ-025 Without AMPEL_NACHT_EN, the night port and the NACHT state SHALL NOT exist.

Structure
REQ-026 Package ampel_pkg SHALL hold the state encoding constants and the default durations.
REQ-027 Sub-module ampel_timer SHALL be a TW-bit loadable down-counter with load, init, count and ready (count==0) signals; the FSM SHALL instantiate it once.

Verification
REQ-028 Defaults, reset then release: phase 0 RGELB at cycle 1, gr[0] for cycles 2-16, GELB at 17, ALLROT at 18, phase 1 RGELB at 19; one full rotation SHALL take 54 cycles.
REQ-029 f_an[0]=1 at green cycle 3 (count=12): count SHALL read 4 the next cycle and GELB SHALL follow after 5 green cycles; f_sg[0] SHALL clear on GELB entry.
REQ-030 f_an[0]=1 when count=2 in phase 0 GRUEN: green SHALL not be extended, f_sg[0] SHALL be set, then cleared at GELB.
REQ-031 f_an[2]=1 during phase 0 green: f_sg[2]=1 held through phases 0-1, phase 2 green shortened to 5 cycles.
REQ-032 reset pulse during GRUEN count=7: outputs SHALL be at reset values within the same cycle, and phase 0 SHALL be next green.
REQ-033 AMPEL_NACHT_EN, night=1: ge SHALL be 111 and 000 alternating each cycle with gr=f_gr=0; night=0 SHALL be followed by 1 cycle ALLROT, then RGELB.
